// File: rtl/hcb_packetizer.sv
// AXI-Stream slave front end for the HCB clause chain. It registers each accepted beat onto x with a one-hot
// packet strobe, and pulses sample_done once the chain's final partial_clause has settled.
module hcb_packetizer #(
   parameter int PACKETS_NUM            = 13,
   parameter int C_S00_AXIS_TDATA_WIDTH = 32,
   parameter int RESULT_LATENCY         = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
   input  logic                              s00_axis_tvalid,
   output logic                              s00_axis_tready,
   input  logic                              s00_axis_tlast,
   input  logic                              hold,
   output logic [C_S00_AXIS_TDATA_WIDTH-1:0] x,
   output logic [PACKETS_NUM-1:0]            valid,
   output logic                              sample_done,
   output logic                              frame_error,
   output logic [15:0]                       sample_count
);

   localparam int IW = (PACKETS_NUM > 1) ? $clog2(PACKETS_NUM) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(PACKETS_NUM - 1);

   logic                              ready_en_q, ready_en_d;
   logic [IW-1:0]                     pkt_idx_q, pkt_idx_d;
   logic [C_S00_AXIS_TDATA_WIDTH-1:0] x_q, x_d;
   logic [PACKETS_NUM-1:0]            valid_q, valid_d;
   logic [RESULT_LATENCY-1:0]         done_pipe_q, done_pipe_d;
   logic                              frame_error_q, frame_error_d;
   logic [15:0]                       sample_count_q, sample_count_d;
   logic                              accept;
   logic                              at_last;

   // Reset also gates ready directly so no beat is taken in the reset cycle itself.
   assign s00_axis_tready = ready_en_q & ~rst & ~((pkt_idx_q == '0) & hold);
   assign accept          = s00_axis_tvalid & s00_axis_tready;
   assign at_last         = (pkt_idx_q == LAST_IDX);

   always_comb begin
      ready_en_d     = 1'b1;
      pkt_idx_d      = pkt_idx_q;
      x_d            = x_q;
      valid_d        = '0;
      frame_error_d  = 1'b0;
      done_pipe_d    = (done_pipe_q << 1) | RESULT_LATENCY'(valid_q[PACKETS_NUM-1]);
      sample_count_d = sample_count_q + 16'(done_pipe_q[RESULT_LATENCY-1]);

      if (accept) begin
         if (s00_axis_tlast && !at_last) begin
            // A short frame is discarded whole; x keeps the last good payload.
            pkt_idx_d     = '0;
            frame_error_d = 1'b1;
         end else begin
            x_d                = s00_axis_tdata;
            valid_d[pkt_idx_q] = 1'b1;
            if (at_last) begin
               pkt_idx_d     = '0;
               frame_error_d = ~s00_axis_tlast;
            end else begin
               pkt_idx_d = pkt_idx_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ready_en_q     <= 1'b0;
         pkt_idx_q      <= '0;
         x_q            <= '0;
         valid_q        <= '0;
         done_pipe_q    <= '0;
         frame_error_q  <= 1'b0;
         sample_count_q <= '0;
      end else begin
         ready_en_q     <= ready_en_d;
         pkt_idx_q      <= pkt_idx_d;
         x_q            <= x_d;
         valid_q        <= valid_d;
         done_pipe_q    <= done_pipe_d;
         frame_error_q  <= frame_error_d;
         sample_count_q <= sample_count_d;
      end
   end

   assign x            = x_q;
   assign valid        = valid_q;
   assign sample_done  = done_pipe_q[RESULT_LATENCY-1];
   assign frame_error  = frame_error_q;
   assign sample_count = sample_count_q;

endmodule

// File: tb/tb_hcb_packetizer.sv
// Bench for hcb_packetizer: a table of beats plus hand-written hold/reset sequences, checked by a queue scoreboard.
// Two instances share stimulus: default latency 1 and latency 4 for the drain case.
module tb_hcb_packetizer;

   typedef struct {
      logic [31:0] d;
      bit          l;
      int          gap;
      logic [12:0] ev;
      bit          ef;
   } vec_t;

   typedef struct {
      int          cyc;
      logic [12:0] v;
      logic [31:0] d;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] tdata;
   logic        tvalid, tlast, hold;
   logic        tready, tready4;
   logic [31:0] x, x4;
   logic [12:0] valid, valid4;
   logic        sample_done, sample_done4, frame_error, frame_error4;
   logic [15:0] sample_count, sample_count4;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   bit          mon_en = 1'b0;
   logic [15:0] exp_cnt = '0;
   logic [15:0] exp_cnt4 = '0;
   ev_t         vq[$];
   int          dq[$];
   int          d4q[$];
   int          fq[$];
   vec_t        vt[57];
   int          n_vec = 0;

   hcb_packetizer #(.PACKETS_NUM(13), .C_S00_AXIS_TDATA_WIDTH(32), .RESULT_LATENCY(1)) dut (
      .clk(clk), .rst(rst), .s00_axis_tdata(tdata), .s00_axis_tvalid(tvalid),
      .s00_axis_tready(tready), .s00_axis_tlast(tlast), .hold(hold), .x(x), .valid(valid),
      .sample_done(sample_done), .frame_error(frame_error), .sample_count(sample_count));

   hcb_packetizer #(.PACKETS_NUM(13), .C_S00_AXIS_TDATA_WIDTH(32), .RESULT_LATENCY(4)) dut_lat4 (
      .clk(clk), .rst(rst), .s00_axis_tdata(tdata), .s00_axis_tvalid(tvalid),
      .s00_axis_tready(tready4), .s00_axis_tlast(tlast), .hold(hold), .x(x4), .valid(valid4),
      .sample_done(sample_done4), .frame_error(frame_error4), .sample_count(sample_count4));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, got, want);
      end
   endtask

   always @(negedge clk) begin : monitor
      ev_t         e;
      logic [12:0] ev;
      logic [31:0] ed;
      bit          de, de4, fe;
      if (mon_en) begin
         ev = '0;
         ed = '0;
         if (vq.size() > 0 && vq[0].cyc == cyc) begin
            e  = vq.pop_front();
            ev = e.v;
            ed = e.d;
         end
         chk("valid", valid, ev);
         chk("valid4", valid4, ev);
         if (ev != 0) begin
            chk("x", x, ed);
            chk("x4", x4, ed);
         end
         chk("sample_count", sample_count, exp_cnt);
         chk("sample_count4", sample_count4, exp_cnt4);
         de = (dq.size() > 0 && dq[0] == cyc);
         if (de) void'(dq.pop_front());
         chk("sample_done", sample_done, de);
         if (de) exp_cnt++;
         de4 = (d4q.size() > 0 && d4q[0] == cyc);
         if (de4) void'(d4q.pop_front());
         chk("sample_done4", sample_done4, de4);
         if (de4) exp_cnt4++;
         fe = (fq.size() > 0 && fq[0] == cyc);
         if (fe) void'(fq.pop_front());
         chk("frame_error", frame_error, fe);
         chk("frame_error4", frame_error4, fe);
      end
   end

   task automatic add(input logic [31:0] d, input bit l, input int gap, input logic [12:0] ev, input bit ef);
      vt[n_vec].d   = d;
      vt[n_vec].l   = l;
      vt[n_vec].gap = gap;
      vt[n_vec].ev  = ev;
      vt[n_vec].ef  = ef;
      n_vec++;
   endtask

   // Entered and left at posedge+1; pushes expectations for the cycle after the accepting edge.
   task automatic send(input logic [31:0] d, input bit l, input int gap, input logic [12:0] ev, input bit ef);
      ev_t e;
      tdata  = d;
      tvalid = 1'b1;
      tlast  = l;
      @(negedge clk);
      chk("tready", tready, 1'b1);
      chk("tready4", tready4, 1'b1);
      @(posedge clk);
      #1;
      tvalid = 1'b0;
      tlast  = 1'b0;
      if (ev != 0) begin
         e.cyc = cyc;
         e.v   = ev;
         e.d   = d;
         vq.push_back(e);
      end
      if (ev[12]) begin
         dq.push_back(cyc + 1);
         d4q.push_back(cyc + 4);
      end
      if (ef) fq.push_back(cyc);
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sample(input logic [31:0] base);
      for (int k = 0; k < 13; k++) send(base + 32'(k), k == 12, 0, 13'(1 << k), 1'b0);
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      @(negedge clk);
      if (mon_en) chk("tready_in_rst", tready, 1'b0);
      @(posedge clk);
      #1;
      vq.delete();
      dq.delete();
      d4q.delete();
      fq.delete();
      exp_cnt  = '0;
      exp_cnt4 = '0;
      mon_en   = 1'b1;
      rst      = 1'b0;
      @(negedge clk);
      chk("rst_x", x, 32'h0);
      chk("rst_valid", valid, 13'h0);
      chk("rst_done", sample_done, 1'b0);
      chk("rst_done4", sample_done4, 1'b0);
      chk("rst_ferr", frame_error, 1'b0);
      chk("rst_count", sample_count, 16'h0);
      chk("rst_count4", sample_count4, 16'h0);
      chk("rst_tready", tready, 1'b0);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      for (int k = 0; k < 13; k++) add(32'(k), k == 12, 0, 13'(1 << k), 1'b0);
      for (int k = 0; k < 13; k++) add(32'hA0 + 32'(k), k == 12, 3, 13'(1 << k), 1'b0);
      for (int k = 0; k < 5; k++) add(32'hC0 + 32'(k), k == 4, 0, (k < 4) ? 13'(1 << k) : 13'h0, k == 4);
      for (int k = 0; k < 13; k++) add(32'hD0 + 32'(k), k == 12, 0, 13'(1 << k), 1'b0);
      for (int k = 0; k < 13; k++) add($urandom, 1'b0, (k == 6) ? 2 : 0, 13'(1 << k), k == 12);

      rst    = 1'b1;
      tdata  = '0;
      tvalid = 1'b0;
      tlast  = 1'b0;
      hold   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_pulse();

      for (int i = 0; i < n_vec; i++) send(vt[i].d, vt[i].l, vt[i].gap, vt[i].ev, vt[i].ef);
      idle(6);
      @(negedge clk);
      chk("count_after_table", sample_count, 16'd4);
      chk("count4_after_table", sample_count4, 16'd4);

      // Hold at the sample boundary stalls packet 0 only.
      @(posedge clk);
      #1;
      hold   = 1'b1;
      tdata  = 32'hB000;
      tvalid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("tready_hold", tready, 1'b0);
         @(posedge clk);
         #1;
      end
      hold = 1'b0;
      for (int k = 0; k < 13; k++) begin
         if (k == 5) hold = 1'b1;
         send(32'hB000 + 32'(k), k == 12, 0, 13'(1 << k), 1'b0);
      end
      tvalid = 1'b1;
      @(negedge clk);
      chk("tready_hold_again", tready, 1'b0);
      @(posedge clk);
      #1;
      tvalid = 1'b0;
      hold   = 1'b0;
      idle(6);
      @(negedge clk);
      chk("count_after_hold", sample_count, 16'd5);
      @(posedge clk);
      #1;

      // Reset mid-sample, then a fresh sample must start again at packet 0.
      for (int k = 0; k < 8; k++) send(32'h700 + 32'(k), 1'b0, 0, 13'(1 << k), 1'b0);
      rst_pulse();
      sample(32'hF00);
      idle(6);
      @(negedge clk);
      chk("count_after_rst", sample_count, 16'd1);
      chk("count4_after_rst", sample_count4, 16'd1);
      @(posedge clk);
      #1;

      // Reset two cycles after the last strobe: latency-4 completion must be lost.
      rst_pulse();
      sample(32'h900);
      idle(2);
      rst_pulse();
      idle(8);
      @(negedge clk);
      chk("count4_drain", sample_count4, 16'd0);
      chk("count_drain", sample_count, 16'd0);
      @(posedge clk);
      #1;
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule

// File: doc/hcb_packetizer.md
# hcb_packetizer

AXI-Stream slave front end that feeds the HCB clause-evaluation chain. It accepts one feature vector as PACKETS_NUM consecutive stream beats. Each accepted beat is registered onto the shared `x` bus, together with a one-cycle, one-hot `valid[k]` strobe for packet index k. After the last packet, the block issues `sample_done` once the chain's final `partial_clause` output is settled. It sits between the DMA/AXIS interconnect and the HCB chain top, and supplies that chain's `x` and `valid` inputs.

## Interface
- `PACKETS_NUM`, 13: beats per sample; equals the number of HCB stages.
- `C_S00_AXIS_TDATA_WIDTH`, 32: stream data width; equals `x` width.
- `RESULT_LATENCY`, 1: cycles from the `valid[PACKETS_NUM-1]` cycle to a stable final `partial_clause`; legal range 1..8.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `s00_axis_tdata`, in, C_S00_AXIS_TDATA_WIDTH: packet payload.
- `s00_axis_tvalid`, in, 1: beat valid.
- `s00_axis_tready`, out, 1: beat accepted when high together with tvalid.
- `s00_axis_tlast`, in, 1: marks the last beat of a sample.
- `hold`, in, 1: downstream busy; stalls acceptance of packet 0 of a new sample.
- `x`, out, C_S00_AXIS_TDATA_WIDTH: registered payload to the HCB chain.
- `valid`, out, PACKETS_NUM: registered one-hot packet strobe.
- `sample_done`, out, 1: one-cycle pulse when the final `partial_clause` is valid.
- `frame_error`, out, 1: one-cycle pulse on a tlast/packet-count mismatch.
- `sample_count`, out, 16: number of completed samples; wraps.

## Operation
- **Packet index.** `pkt_idx` counts 0..PACKETS_NUM-1.
  - Each accepted beat drives `x <= tdata` and `valid <= (1 << pkt_idx)`.
  - `pkt_idx` then increments, wrapping from PACKETS_NUM-1 to 0.
  - With no accepted beat, `valid <= 0` and `x` holds its last value.
- **Ready.** `s00_axis_tready = ready_en & ~(pkt_idx==0 & hold)`.
  - `ready_en` is a register: cleared by `rst`, set 1 the first cycle after reset deasserts.
  - `hold` has no effect mid-sample (`pkt_idx` != 0).
- **Early tlast.** An accepted beat with tlast=1 and `pkt_idx` < PACKETS_NUM-1:
  - the beat is dropped, so `valid` stays 0;
  - `pkt_idx <= 0` and `frame_error` pulses;
  - no `sample_done` is produced for the partial sample.
- **Missing tlast.** An accepted beat with `pkt_idx`==PACKETS_NUM-1 and tlast=0:
  - the beat is issued normally and the sample completes;
  - `frame_error` pulses and `pkt_idx` wraps to 0.
- **Completion pipeline.** A RESULT_LATENCY-deep shift register is loaded with 1 in every cycle where `valid[PACKETS_NUM-1]` is high.
  - Its output is `sample_done`.
  - `sample_count` increments on every `sample_done`, wrapping 0xFFFF -> 0x0000.
- **Overlap.** Samples may overlap in flight: packet 0 of sample n+1 may be accepted while sample n drains through the completion pipeline.
- **Reset.** `rst` in any cycle, including mid-sample or mid-drain, forces:
  - `pkt_idx`=0 and the completion pipeline all zero;
  - `x`=0, `valid`=0, `sample_done`=0, `frame_error`=0, `sample_count`=0, `s00_axis_tready`=0.
  - Any in-flight partial sample and any pending completion are discarded.

## Timing
- A beat accepted at edge N gives `x`/`valid` high for exactly the cycle following edge N. Input-to-strobe latency is 1 cycle.
- Back-to-back beats give consecutive one-hot strobes 1 cycle apart. This is the HCB chain's minimum packet spacing; there are no bubbles in the chain requirement.
- If `valid[PACKETS_NUM-1]` is high in cycle c, `sample_done` is high in cycle c+RESULT_LATENCY only.
- `frame_error` is high in the cycle after the offending acceptance edge.
- `s00_axis_tready` is combinational from registers plus `hold`. There is no combinational path from tvalid to tready.
- Exactly one bit of `valid` is high in any cycle, or none.

## Test plan
- **Single sample.** Defaults; after reset, 13 back-to-back beats with tdata=k, tlast on beat 12 -> `valid` walks 0x0001..0x1000 over 13 cycles with x=0..12; `sample_done` 1 cycle after the 0x1000 cycle; `sample_count`=1; no `frame_error`.
- **Gapped stream.** tvalid deasserted 3 cycles between every beat -> identical one-hot sequence with `valid`=0 during gaps; `sample_done` once; `sample_count`=1.
- **Hold at boundary.** `hold`=1 after the sample completes, tvalid=1 -> tready=0 and `valid`=0. Release `hold` -> beat 0 accepted next edge; `valid`=0x0001 the following cycle. `hold`=1 asserted at `pkt_idx`=5 -> no stall.
- **Early tlast.** tlast on beat 4 -> beats 0..3 issued, beat 4 dropped, `frame_error` pulse, no `sample_done`. The following full 13-beat sample completes normally with `sample_count`=1.
- **Reset mid-sample and mid-drain.** `rst` after beat 7 -> all outputs 0. The next 13-beat sample restarts at `valid`=0x0001. With RESULT_LATENCY=4, `rst` 2 cycles after `valid`=0x1000 -> no `sample_done`; `sample_count` stays 0.
- **Counter wrap.** Preload by streaming 65536 samples -> `sample_count` returns to 0x0000 on the 65536th `sample_done`.
